// File: rtl/phase_gen_pkg.sv
// -----------------------------------------------------------------------------
// phase_gen_pkg
// Definitions shared by the phase-pulse generator and its per-channel slot
// comparator.
//   DEF_CNT_W     : default counter / period / slot width in bits
//   DEF_NUM_CH    : default number of phase-pulse channels
//   phase_state_t : controller states. DONE is reachable only when the design
//                   is built with PHASE_GEN_ONESHOT_EN defined.
// -----------------------------------------------------------------------------
package phase_gen_pkg;

    localparam int DEF_CNT_W  = 3;
    localparam int DEF_NUM_CH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } phase_state_t;

endpackage

// File: rtl/phase_slot_cmp.sv
// -----------------------------------------------------------------------------
// phase_slot_cmp
// One channel of the phase-pulse generator. It registers a pulse for the
// cycle in which the counter will sit on this channel's slot.
//
// The inputs are the values the controller is about to load (next count,
// next shadow slot, next shadow enable). Registering the compare of those
// values keeps pulse cycle-aligned with the registered count and wrap.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   active     : controller will be in RUN next cycle
//   count_nxt  : counter value for next cycle
//   slot_nxt   : shadow slot for next cycle
//   en_nxt     : shadow channel enable for next cycle
//   pulse      : registered one-cycle data-enable pulse
// -----------------------------------------------------------------------------
module phase_slot_cmp
    import phase_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic [CNT_W-1:0] count_nxt,
    input  logic [CNT_W-1:0] slot_nxt,
    input  logic             en_nxt,
    output logic             pulse
);

    // A slot beyond the period never compares equal, because the counter
    // never reaches it, so no extra range check is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse <= 1'b0;
        end else begin
            pulse <= active && en_nxt && (count_nxt == slot_nxt);
        end
    end

endmodule

// File: rtl/phase_pulse_gen.sv
// -----------------------------------------------------------------------------
// phase_pulse_gen
// Free-running phase counter that emits one data-enable pulse per channel
// per period, at a programmable slot. The period, slots and enables are
// shadowed at start and at every wrap boundary, so changing them in the
// middle of a period has no effect until the next period begins.
//
// Optional feature: defining PHASE_GEN_ONESHOT_EN adds the oneshot input.
// When oneshot is sampled high at start, the block runs one period, then
// parks in DONE (busy=1) until run is dropped.
//
// Ports
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   run     : level; 1 = count, 0 = stop at the end of the current period
//   period  : terminal count (the counter runs 0..period)
//   ch_slot : channel i slot in bits [i*CNT_W +: CNT_W]
//   ch_en   : per-channel pulse enable
//   oneshot : (PHASE_GEN_ONESHOT_EN only) run a single period
//   pulse   : registered per-channel slot pulses
//   count   : registered counter value
//   wrap    : registered; high while count == active period in RUN
//   busy    : registered; high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module phase_pulse_gen
    import phase_gen_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] ch_slot,
    input  logic [NUM_CH-1:0]       ch_en,
`ifdef PHASE_GEN_ONESHOT_EN
    input  logic                    oneshot,
`endif
    output logic [NUM_CH-1:0]       pulse,
    output logic [CNT_W-1:0]        count,
    output logic                    wrap,
    output logic                    busy
);

    phase_state_t              state, state_nxt;
    logic [CNT_W-1:0]          count_nxt;
    logic [CNT_W-1:0]          sh_period, sh_period_nxt;
    logic [NUM_CH*CNT_W-1:0]   sh_slot, sh_slot_nxt;
    logic [NUM_CH-1:0]         sh_en, sh_en_nxt;
    logic                      load;
    logic                      active_nxt;
    logic                      wrap_nxt;
    logic                      busy_nxt;
`ifdef PHASE_GEN_ONESHOT_EN
    logic                      sh_oneshot, sh_oneshot_nxt;
`endif

    // Next-state logic. All registered outputs are derived from these next
    // values so that count, wrap and pulse describe the same cycle.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt     = state;
        count_nxt     = count;
        sh_period_nxt = sh_period;
        sh_slot_nxt   = sh_slot;
        sh_en_nxt     = sh_en;
        load          = 1'b0;
`ifdef PHASE_GEN_ONESHOT_EN
        sh_oneshot_nxt = sh_oneshot;
`endif

        case (state)
            IDLE: begin
                count_nxt = '0;
                if (run) begin
                    state_nxt = RUN;
                    load      = 1'b1;
`ifdef PHASE_GEN_ONESHOT_EN
                    sh_oneshot_nxt = oneshot;
`endif
                end
            end

            RUN: begin
                if (count == sh_period) begin
                    // Wrap boundary: the only place the shadows reload and
                    // the only place a stop request is honoured. Sampling
                    // run here means a re-assert before the wrap cancels it.
                    count_nxt = '0;
                    load      = 1'b1;
`ifdef PHASE_GEN_ONESHOT_EN
                    if (sh_oneshot) begin
                        state_nxt = DONE;
                    end else
`endif
                    if (!run) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end

`ifdef PHASE_GEN_ONESHOT_EN
            DONE: begin
                count_nxt = '0;
                if (!run) begin
                    state_nxt = IDLE;
                end
            end
`endif

            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase

        if (load) begin
            sh_period_nxt = period;
            sh_slot_nxt   = ch_slot;
            sh_en_nxt     = ch_en;
        end
    end

    assign active_nxt = (state_nxt == RUN);
    assign wrap_nxt   = active_nxt && (count_nxt == sh_period_nxt);
    assign busy_nxt   = (state_nxt != IDLE);

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the shadows are plain registers, not a memory array,
            // so clearing them on reset costs nothing and is required.
            state     <= IDLE;
            count     <= '0;
            wrap      <= 1'b0;
            busy      <= 1'b0;
            sh_period <= '0;
            sh_slot   <= '0;
            sh_en     <= '0;
`ifdef PHASE_GEN_ONESHOT_EN
            sh_oneshot <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            wrap      <= wrap_nxt;
            busy      <= busy_nxt;
            sh_period <= sh_period_nxt;
            sh_slot   <= sh_slot_nxt;
            sh_en     <= sh_en_nxt;
`ifdef PHASE_GEN_ONESHOT_EN
            sh_oneshot <= sh_oneshot_nxt;
`endif
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        phase_slot_cmp #(
            .CNT_W (CNT_W)
        ) u_cmp (
            .clk       (clk),
            .rst       (rst),
            .active    (active_nxt),
            .count_nxt (count_nxt),
            .slot_nxt  (sh_slot_nxt[i*CNT_W +: CNT_W]),
            .en_nxt    (sh_en_nxt[i]),
            .pulse     (pulse[i])
        );
    end

endmodule

// File: tb/tb_phase_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_phase_pulse_gen
// Self-checking bench for phase_pulse_gen (default build, CNT_W=3, NUM_CH=2).
// A period-level reference model predicts count/wrap/busy/pulse for every
// cycle; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_phase_pulse_gen;

    localparam int CNT_W  = 3;
    localparam int NUM_CH = 2;

    logic                    clk;
    logic                    rst;
    logic                    run;
    logic [CNT_W-1:0]        period;
    logic [NUM_CH*CNT_W-1:0] ch_slot;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       pulse;
    logic [CNT_W-1:0]        count;
    logic                    wrap;
    logic                    busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    phase_pulse_gen #(
        .CNT_W  (CNT_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .period  (period),
        .ch_slot (ch_slot),
        .ch_en   (ch_en),
        .pulse   (pulse),
        .count   (count),
        .wrap    (wrap),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model thinks in periods: whether a period is in progress, the
    // position within it, and the settings latched for it.
    bit m_running = 1'b0;
    int m_pos     = 0;
    int m_per     = 0;
    int m_slot [NUM_CH];
    bit m_en   [NUM_CH];

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_slot[i] = 0;
            m_en[i]   = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_running <= 1'b0;
            m_pos     <= 0;
            m_per     <= 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_slot[i] <= 0;
                m_en[i]   <= 1'b0;
            end
        end else if (!m_running) begin
            if (run) begin
                m_running <= 1'b1;
                m_pos     <= 0;
                m_per     <= int'(period);
                for (int i = 0; i < NUM_CH; i++) begin
                    m_slot[i] <= int'(ch_slot[i*CNT_W +: CNT_W]);
                    m_en[i]   <= ch_en[i];
                end
            end
        end else if (m_pos == m_per) begin
            // End of period: next period starts with fresh settings, and
            // continues only if run is still requested.
            m_running <= run;
            m_pos     <= 0;
            m_per     <= int'(period);
            for (int i = 0; i < NUM_CH; i++) begin
                m_slot[i] <= int'(ch_slot[i*CNT_W +: CNT_W]);
                m_en[i]   <= ch_en[i];
            end
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            int exp_count;
            int exp_pulse;
            exp_count = m_running ? m_pos : 0;
            exp_pulse = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_running && m_en[i] && (m_slot[i] == m_pos)) begin
                    exp_pulse = exp_pulse | (1 << i);
                end
            end
            check("model_count", int'(count), exp_count);
            check("model_wrap",  int'(wrap),  int'(m_running && (m_pos == m_per)));
            check("model_busy",  int'(busy),  int'(m_running));
            check("model_pulse", int'(pulse), exp_pulse);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance until the DUT shows count == v while busy, within a budget.
    task automatic wait_count(input int v);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!((int'(count) == v) && busy) && (k < 40));
        if (!((int'(count) == v) && busy)) begin
            checks++;
            errors++;
            $display("FAIL wait_count: count %0d never reached, last %0d", v, count);
        end
    endtask

    initial begin
        rst     = 1'b1;
        run     = 1'b0;
        period  = '0;
        ch_slot = '0;
        ch_en   = '0;

        // Reset state
        tick(3);
        cmp_en = 1'b1;
        check("rst_count", int'(count), 0);
        check("rst_busy",  int'(busy),  0);
        check("rst_pulse", int'(pulse), 0);
        check("rst_wrap",  int'(wrap),  0);

        // Basic run: period 7, slots {2,5}, both enabled
        rst     = 1'b0;
        period  = 3'd7;
        ch_slot = {3'd5, 3'd2};
        ch_en   = 2'b11;
        run     = 1'b1;
        tick(1);
        check("start_count", int'(count), 0);
        check("start_busy",  int'(busy),  1);
        tick(2);
        check("p7_cnt2_pulse", int'(pulse), 1);
        tick(3);
        check("p7_cnt5_count", int'(count), 5);
        check("p7_cnt5_pulse", int'(pulse), 2);
        tick(2);
        check("p7_cnt7_wrap",  int'(wrap),  1);
        check("p7_cnt7_pulse", int'(pulse), 0);
        tick(1);
        check("p7_restart_count", int'(count), 0);

        // Period change mid-period: 7 -> 3 at count 4
        tick(4);
        check("chg_at4", int'(count), 4);
        period = 3'd3;
        tick(3);
        check("chg_old_wrap_count", int'(count), 7);
        check("chg_old_wrap",       int'(wrap),  1);
        tick(1);
        check("chg_new_count0", int'(count), 0);
        tick(3);
        check("chg_new_wrap_count", int'(count), 3);
        check("chg_new_wrap",       int'(wrap),  1);
        check("chg_slot5_silent",   int'(pulse), 0);
        tick(2);
        check("chg_short_period", int'(count), 1);

        // Stop request: drop at 2, re-raise at 5 (no stop), then real stop
        period = 3'd7;
        wait_count(7);
        tick(1);
        wait_count(2);
        run = 1'b0;
        wait_count(5);
        run = 1'b1;
        wait_count(7);
        tick(1);
        check("cancel_stop_busy",  int'(busy),  1);
        check("cancel_stop_count", int'(count), 0);
        wait_count(2);
        run = 1'b0;
        wait_count(7);
        check("stop_pending_busy", int'(busy), 1);
        tick(1);
        check("stop_idle_busy",  int'(busy),  0);
        check("stop_idle_count", int'(count), 0);
        tick(2);
        check("stay_idle_busy", int'(busy), 0);

        // period = 0: wrap and slot-0 pulse every cycle; ch1 disabled
        period  = 3'd0;
        ch_slot = {3'd0, 3'd0};
        ch_en   = 2'b01;
        run     = 1'b1;
        tick(1);
        check("p0_count", int'(count), 0);
        check("p0_wrap",  int'(wrap),  1);
        check("p0_pulse", int'(pulse), 1);
        tick(3);
        check("p0_wrap_again",  int'(wrap),  1);
        check("p0_pulse_again", int'(pulse), 1);

        // Equal slots pulse together; slot change takes effect at next wrap
        period  = 3'd3;
        ch_slot = {3'd1, 3'd1};
        ch_en   = 2'b11;
        tick(1);
        check("eq_cnt0_wrap",  int'(wrap),  0);
        check("eq_cnt0_pulse", int'(pulse), 0);
        tick(1);
        check("eq_cnt1_pulse", int'(pulse), 3);

        // Reset mid-period with run held high
        period = 3'd7;
        wait_count(4);
        rst = 1'b1;
        tick(1);
        check("midrst_count", int'(count), 0);
        check("midrst_busy",  int'(busy),  0);
        check("midrst_pulse", int'(pulse), 0);
        rst = 1'b0;
        tick(1);
        check("rst_restart_count", int'(count), 0);
        check("rst_restart_busy",  int'(busy),  1);
        tick(1);
        check("rst_restart_cnt1_pulse", int'(pulse), 3);

        // Final stop
        run = 1'b0;
        begin
            int k;
            k = 0;
            while (busy && (k < 20)) begin
                @(negedge clk);
                k++;
            end
        end
        check("final_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, busy=%0d", busy);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/phase_pulse_gen.md
PHASE_PULSE_GEN -- requirements
Module: phase_pulse_gen

Interface
REQ-001 Parameter CNT_W, default 3: counter, period and slot width in bits (2..16).
REQ-002 Parameter NUM_CH, default 2: number of independent phase-pulse channels (1..8).
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset; synchronous, active-high.
REQ-005 Port run, input, 1: level; 1 requests counting, 0 requests stop.
REQ-006 Port period, input, CNT_W: terminal count; the counter runs 0..period inclusive.
REQ-007 Port ch_slot, input, NUM_CH*CNT_W: channel i's phase slot in bits [i*CNT_W +: CNT_W].
REQ-008 Port ch_en, input, NUM_CH: per-channel pulse enable.
REQ-009 Port pulse, output, NUM_CH: registered one-cycle-per-slot enable pulses (data enables, never gated clocks).
REQ-010 Port count, output, CNT_W: registered current counter value.
REQ-011 Port wrap, output, 1: registered; high in the cycle where count == active period while RUN.
REQ-012 Port busy, output, 1: registered; high while the state machine is not IDLE.

Function
REQ-013 The state machine SHALL have states IDLE, RUN and DONE; DONE exists only with PHASE_GEN_ONESHOT_EN.
REQ-014 IDLE->RUN on run=1: the counter loads 0, and period, ch_slot and ch_en are captured into shadow registers in the same edge.
REQ-015 In RUN, count SHALL increment by 1 per cycle and load 0 on the cycle after count == shadow period (modulo period+1).
REQ-016 Shadow period/slot/enable registers SHALL reload only at a wrap boundary (count == shadow period); mid-period input changes have no effect until the next period.
REQ-017 pulse[i] SHALL be 1 in exactly the cycles where RUN, count == shadow slot_i and shadow en_i = 1; otherwise 0.
REQ-018 Latency: pulse, count and wrap are mutually cycle-aligned; the first count=0 appears one cycle after run rises.
REQ-019 A slot greater than shadow period SHALL never pulse; multiple channels with equal slots SHALL pulse simultaneously.
REQ-020 period=0: count SHALL remain 0, wrap SHALL be high every RUN cycle, and slot-0 channels SHALL pulse every cycle.
REQ-021 run=0 in RUN SHALL take effect only at the wrap boundary (the period completes), then go to IDLE; run re-asserted before wrap cancels the stop.
REQ-022 In IDLE, count SHALL hold 0 and pulse, wrap and busy SHALL be 0.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, count=0, pulse=0, wrap=0, busy=0, and all shadow registers to 0, overriding run in any state, including mid-period.
REQ-024 run held high through reset release SHALL start counting on the first edge after rst falls.

Configuration
REQ-025 Macro PHASE_GEN_ONESHOT_EN: when defined, it adds input oneshot (1 bit); when oneshot=1 is sampled at start, the block SHALL run exactly one period, enter DONE, and stay there (busy=1, pulse=0) until run=0, which returns it to IDLE.
REQ-026 Without PHASE_GEN_ONESHOT_EN there is no oneshot port and no DONE state; operation is continuous per REQ-015/REQ-021.

Structure
REQ-027 A shared package phase_gen_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the default CNT_W/NUM_CH constants.
REQ-028 Per-channel slot compare and enable SHALL be one sub-module, phase_slot_cmp, instantiated NUM_CH times via generate.

Verification
REQ-029 CNT_W=3, period=7, slots {2,5}, en=11, run=1 -> pulse[0] at counts 2 and pulse[1] at counts 5, every 8 cycles; wrap at count 7.
REQ-030 Change period 7->3 at count 4 -> current period completes to 7, next period wraps at 3; slot 5 channel stops pulsing.
REQ-031 period=0, slot0=0 -> count stays 0, wrap and pulse[0] high every RUN cycle.
REQ-032 run drops at count 2 (period 7) -> counting continues through 7, then IDLE with busy=0; re-raise at count 5 -> no stop.
REQ-033 rst pulsed at count 4 -> next cycle count=0, pulse=0, IDLE; run held high -> restart at count 0.
REQ-034 With PHASE_GEN_ONESHOT_EN, oneshot=1, period=5 -> counts 0..5 once, DONE with busy=1, pulse=0; run=0 -> IDLE.
